// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution datapath (feeder and MAC).
//   feeder_state_t : window feeder FSM state (FILL, EMIT)
//   CONV_WIDTH     : default sample/weight width
//   CONV_ACC_WIDTH : default accumulator/bias width
//   addr_w()       : tap-index width for an n-entry bank (never below 1)
package conv_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } feeder_state_t;

  localparam int CONV_WIDTH     = 8;
  localparam int CONV_ACC_WIDTH = 32;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_weight_rf.sv
// conv_weight_rf: TAPS x WIDTH weight bank.
//   clk, rst_n : clock, async active-low reset (bank clears to zero)
//   we, waddr, wdata : write port; an out-of-range waddr matches no entry, so it is dropped
//   raddr, rdata     : combinational read port; an out-of-range raddr reads 0
module conv_weight_rf
  import conv_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int TAPS  = 9,
  parameter int AW    = addr_w(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < TAPS; i++)
        if (waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < TAPS) ? mem[raddr] : '0;

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a sample stream into TAPS-beat (sample, weight)
// windows for the MAC. Stride-1 sliding window, s_first restarts the row.
//   s_valid/s_ready/s_first/s_data : sample input (ready only while not emitting)
//   w_valid/w_ready/w_addr/w_data  : weight writes (ready only while not emitting)
//   bias_en/bias_cfg               : quasi-static bias attached to each window's first beat
//   in_valid/in_first/in_last/a_in/b_in/bias_valid/bias_in : registered MAC stream
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH     = CONV_WIDTH,
  parameter int ACC_WIDTH = CONV_ACC_WIDTH,
  parameter int TAPS      = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_first,
  input  logic [WIDTH-1:0]          s_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [addr_w(TAPS)-1:0]   w_addr,
  input  logic [WIDTH-1:0]          w_data,
  input  logic                      bias_en,
  input  logic [ACC_WIDTH-1:0]      bias_cfg,
  output logic                      in_valid,
  output logic                      in_first,
  output logic                      in_last,
  output logic [WIDTH-1:0]          a_in,
  output logic [WIDTH-1:0]          b_in,
  output logic                      bias_valid,
  output logic [ACC_WIDTH-1:0]      bias_in
);

  localparam int AW = addr_w(TAPS);
  localparam int CW = $clog2(TAPS + 1);

  feeder_state_t                state;
  logic [CW-1:0]                fill, fill_nxt;
  logic [CW-1:0]                idx;   // next beat to load while emitting
  logic [TAPS-1:0][WIDTH-1:0]   win;   // win[0] is the oldest sample
  logic                         s_fire, w_fire, win_done;
  logic [AW-1:0]                rd_addr;
  logic [WIDTH-1:0]             rd_data, a0, b0;

  assign s_fire   = s_valid && s_ready;
  assign w_fire   = w_valid && w_ready;
  assign fill_nxt = s_first ? CW'(1) : (fill == CW'(TAPS)) ? fill : fill + 1'b1;
  assign win_done = s_fire && (fill_nxt == CW'(TAPS));
  assign rd_addr  = (state == EMIT) ? idx[AW-1:0] : '0;

  conv_weight_rf #(.WIDTH(WIDTH), .TAPS(TAPS), .AW(AW)) u_wrf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_fire),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Beat 0 is loaded on the same edge that accepts the completing sample, so
  // it comes from the post-shift window and sees a weight written that cycle.
  if (TAPS > 1) begin : g_a0_win
    assign a0 = win[1];
  end else begin : g_a0_new
    assign a0 = s_data;
  end
  assign b0 = (w_fire && w_addr == '0) ? w_data : rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fill       <= '0;
      idx        <= '0;
      win        <= '0;
      s_ready    <= 1'b0;
      w_ready    <= 1'b0;
      in_valid   <= 1'b0;
      in_first   <= 1'b0;
      in_last    <= 1'b0;
      a_in       <= '0;
      b_in       <= '0;
      bias_valid <= 1'b0;
      bias_in    <= '0;
    end else begin
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          w_ready <= 1'b1;
          if (s_fire) begin
            fill <= fill_nxt;
            for (int i = 0; i < TAPS - 1; i++) win[i] <= win[i+1];
            win[TAPS-1] <= s_data;
          end
          if (win_done) begin
            state      <= EMIT;
            s_ready    <= 1'b0;
            w_ready    <= 1'b0;
            idx        <= CW'(1);
            in_valid   <= 1'b1;
            in_first   <= 1'b1;
            in_last    <= (TAPS == 1);
            a_in       <= a0;
            b_in       <= b0;
            bias_valid <= bias_en;
            bias_in    <= bias_cfg;
          end
        end
        EMIT: begin
          if (in_last) begin
            state      <= FILL;
            s_ready    <= 1'b1;
            w_ready    <= 1'b1;
            idx        <= '0;
            in_valid   <= 1'b0;
            in_first   <= 1'b0;
            in_last    <= 1'b0;
            a_in       <= '0;
            b_in       <= '0;
            bias_valid <= 1'b0;
            bias_in    <= '0;
          end else begin
            idx        <= idx + 1'b1;
            in_first   <= 1'b0;
            in_last    <= (idx == CW'(TAPS - 1));
            a_in       <= win[idx];
            b_in       <= rd_data;
            bias_valid <= 1'b0;
            bias_in    <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed + randomized check of conv_window_feeder
// (TAPS=3) against a transaction-level model: accepted samples are kept as a
// row history, each full window pushes TAPS expected beats into a queue, and
// the queue front is compared with the MAC stream every cycle.
module tb_conv_window_feeder;
  localparam int W  = 8;
  localparam int AC = 32;
  localparam int T  = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 0, s_first = 0, w_valid = 0, bias_en = 0;
  logic [W-1:0]  s_data = '0, w_data = '0;
  logic [1:0]    w_addr = '0;
  logic [AC-1:0] bias_cfg = '0;
  logic          s_ready, w_ready, in_valid, in_first, in_last, bias_valid;
  logic [W-1:0]  a_in, b_in;
  logic [AC-1:0] bias_in;

  conv_window_feeder #(.WIDTH(W), .ACC_WIDTH(AC), .TAPS(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first), .s_data(s_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .bias_en(bias_en), .bias_cfg(bias_cfg),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .bias_valid(bias_valid), .bias_in(bias_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  a, b;
    logic          first, last, bv;
    logic [AC-1:0] bi;
  } beat_t;

  beat_t         q[$];
  logic [W-1:0]  hist[$];
  logic [W-1:0]  wt[T];
  bit            started;
  logic          nb_en = 0;
  logic [AC-1:0] nb_cfg = '0;
  int            n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    for (int i = 0; i < T; i++) wt[i] = '0;
    started = 0;
  endtask

  // Effect of the coming clock edge, given the inputs just driven.
  task automatic model_edge(input logic sv, input logic sf, input logic [W-1:0] sd,
                            input logic wv, input logic [1:0] wa, input logic [W-1:0] wd);
    beat_t b;
    if (!started) begin
      started = 1;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else begin
      if (wv && wa < T) wt[wa] = wd;
      if (sv) begin
        if (sf) hist.delete();
        hist.push_back(sd);
        if (hist.size() > T) void'(hist.pop_front());
        if (hist.size() == T)
          for (int i = 0; i < T; i++) begin
            b.a = hist[i]; b.b = wt[i];
            b.first = (i == 0); b.last = (i == T - 1);
            b.bv = (i == 0) ? bias_en : 1'b0;
            b.bi = (i == 0) ? bias_cfg : '0;
            q.push_back(b);
          end
      end
    end
  endtask

  task automatic check_outputs();
    beat_t e;
    logic  rdy;
    e   = '0;
    rdy = started && q.size() == 0;
    if (q.size() > 0) e = q[0];
    chk("s_ready", s_ready, rdy);
    chk("w_ready", w_ready, rdy);
    chk("in_valid", in_valid, q.size() > 0);
    chk("a_in", a_in, e.a);
    chk("b_in", b_in, e.b);
    chk("in_first", in_first, e.first);
    chk("in_last", in_last, e.last);
    chk("bias_valid", bias_valid, e.bv);
    chk("bias_in", bias_in, e.bi);
  endtask

  task automatic step(input logic sv, input logic sf, input logic [W-1:0] sd,
                      input logic wv, input logic [1:0] wa, input logic [W-1:0] wd,
                      output logic rdy);
    @(negedge clk);
    check_outputs();
    rdy = started && q.size() == 0;
    s_valid = sv; s_first = sf; s_data = sd;
    w_valid = wv; w_addr = wa; w_data = wd;
    bias_en = nb_en; bias_cfg = nb_cfg;
    model_edge(sv, sf, sd, wv, wa, wd);
  endtask

  // Hold s_valid until the sample is taken.
  task automatic send(input logic [W-1:0] d, input logic f,
                      input logic wv, input logic [1:0] wa, input logic [W-1:0] wd);
    logic r;
    int   k;
    k = 0;
    do begin
      step(1'b1, f, d, wv, wa, wd, r);
      k++;
    end while (!r && k < 40);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, r);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 0; w_valid = 0;
    model_edge(0, 0, '0, 0, '0, '0);
  endtask

  initial begin
    logic r;
    int   k;
    model_reset();
    // reset state
    repeat (2) begin @(negedge clk); check_outputs(); end
    release_reset();

    // weights {1,2,3}, window 10,20,30
    for (int i = 0; i < T; i++) step(0, 0, '0, 1, 2'(i), 8'(i + 1), r);
    send(8'd10, 1, 0, 0, 0);
    send(8'd20, 0, 0, 0, 0);
    send(8'd30, 0, 0, 0, 0);
    // sliding window with bias, s_valid held through the stall
    nb_en = 1; nb_cfg = 32'h100;
    send(8'd40, 0, 0, 0, 0);
    // weight write held across the window
    k = 0;
    do begin step(0, 0, '0, 1, 2'd1, 8'd5, r); k++; end while (!r && k < 40);
    if (!r) chk("wr_timeout", 0, 1);
    nb_en = 0;
    send(8'd50, 1, 0, 0, 0);
    send(8'd60, 0, 0, 0, 0);
    send(8'd70, 0, 0, 0, 0);
    idle(T + 2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) begin
        nb_en  = 1'($urandom);
        nb_cfg = $urandom;
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 8'($urandom),
           1'($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), 8'($urandom), r);
    end

    // reset during beat 1 of a window
    k = 0;
    while (q.size() != T - 1 && k < 200) begin
      step(1, 0, 8'($urandom), 0, 0, 0, r);
      k++;
    end
    if (q.size() != T - 1) chk("emit_timeout", 0, 1);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    s_valid = 0; w_valid = 0;
    model_reset();
    #1;
    check_outputs();
    release_reset();
    // full refill with cleared weights
    send(8'd7, 0, 0, 0, 0);
    send(8'd8, 0, 0, 0, 0);
    send(8'd9, 0, 0, 0, 0);
    idle(T + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of the convolution MAC datapath. It accepts a stream of samples over a valid/ready handshake and holds a programmable TAPS-entry weight bank. For every complete sliding window of TAPS samples, it drives the MAC input stream: TAPS consecutive (sample, weight) pairs framed by first/last flags, with optional bias on the first pair. The MAC's input is always-ready, so this block alone paces the stream; upstream sources are throttled through s_ready.

## Interface
- WIDTH, 8, sample/weight bit-width (matches the MAC).
- ACC_WIDTH, 32, bias width (matches the MAC).
- TAPS, 9, window length (≥1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- s_first  in  1  first sample of a new row; clears the window.
- s_data  in  WIDTH  sample.
- w_valid  in  1  weight write request.
- w_ready  out  1  weight write accepted when w_valid && w_ready.
- w_addr  in  $clog2(TAPS) (min 1)  tap index.
- w_data  in  WIDTH  weight value.
- bias_en  in  1  quasi-static; attach bias to each window.
- bias_cfg  in  ACC_WIDTH  quasi-static bias value.
- in_valid, in_first, in_last  out  1  MAC stream framing.
- a_in  out  WIDTH  sample to the MAC.
- b_in  out  WIDTH  weight to the MAC.
- bias_valid  out  1  bias qualifier.
- bias_in  out  ACC_WIDTH  bias to the MAC.

## Operation
- Window storage is a shift register `win[0..TAPS-1]`. `win[0]` is the oldest sample.
- An accepted sample shifts in at `win[TAPS-1]`.
- Fill counter `fill` is 0..TAPS and saturates at TAPS.
- An accepted sample with s_first=1 sets fill=1. Older entries become don't-care.
- FSM states: FILL, EMIT.
  - FILL: s_ready=1.
    - Accept with post-accept fill==TAPS → EMIT, idx=0.
    - Otherwise stay in FILL.
  - EMIT: s_ready=0. Each cycle emits pair idx: a_in=win[idx], b_in=wt[idx].
    - in_first=(idx==0), in_last=(idx==TAPS-1).
    - At idx==TAPS-1 → FILL.
- Sliding behaviour: once fill is saturated, every further accepted sample (without s_first) produces one window, stride 1.
- Bias:
  - bias_valid=bias_en, asserted only on the in_first beat.
  - bias_in=bias_cfg on that beat; 0 otherwise.
- Weights:
  - w_ready=1 in FILL, 0 in EMIT, so weights never change mid-window.
  - An accepted write updates wt[w_addr] on the next edge.
  - w_addr ≥ TAPS is ignored (write accepted, no effect).
  - Same-cycle sample accept and weight write: the write precedes the window emission, so the new weight is used.
- Data are bit-passthrough; signedness is the MAC's concern. The only arithmetic is the fill and idx counters, each $clog2(TAPS+1) bits.
- When in_valid=0, a_in, b_in, in_first, in_last, bias_valid and bias_in are all driven to 0.

## Timing
- All outputs are registered.
- Reset values:
  - s_ready=0, w_ready=0.
  - in_valid, in_first, in_last, bias_valid = 0.
  - a_in, b_in, bias_in = 0.
  - Internal: fill=0, idx=0, state=FILL, wt[*]=0, win[*]=0.
- s_ready and w_ready rise on the first clk edge after rst_n deasserts.
- Latency: the sample completing a window is accepted at edge t. Beat 0 is valid in the cycle after edge t; beat TAPS-1 is valid TAPS-1 cycles later.
- s_ready is low for exactly TAPS cycles (the beats) and returns high in the cycle after the last beat.
- Peak throughput is one window per TAPS+1 cycles.
- TAPS=1: a single beat per window with in_first=in_last=1.
- Reset mid-EMIT: outputs clear asynchronously and the window is lost. No partial window resumes, and the MAC sees no in_last.

## Structure
- `conv_pkg` holds the FSM state enum (`feeder_state_t`: FILL, EMIT) and shared width defaults (WIDTH, ACC_WIDTH). The package is shared with the MAC.
- One sub-module, `conv_weight_rf`: TAPS×WIDTH register file with one write port and one combinational read port, async reset to zero.

## Test plan
- TAPS=3, weights {1,2,3}, samples 10(s_first),20,30 → one 3-beat window: a=10,20,30; b=1,2,3; first on beat 0, last on beat 2; MAC sum 140.
- Continue with sample 40 → window a=20,30,40 (sum 200). s_ready is low exactly 3 cycles per window, and s_valid held high stalls correctly.
- s_first on sample 50 after a full window → no output until two more samples (60, 70) arrive; the next window is a=50,60,70.
- Hold w_valid (addr 1, data 5) during EMIT → w_ready=0 until FILL. The current window uses b=2; the next window uses b=5.
- bias_en=1, bias_cfg=0x100 → bias_valid=1 and bias_in=0x100 on in_first beats only. bias_en=0 → bias_valid never asserts.
- Assert rst_n=0 on beat 1 of a window → all outputs 0 immediately. After release, s_ready=1 one edge later, weights read 0, and a full refill is required.
